// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline definitions. Holds the register-address type
//               used by the register file, forwarding unit, IDEX and the
//               hazard scoreboard, plus the producer latency classes.
//               Latency class = stall cycles a producer owes to an
//               immediately following consumer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int PIPE_ADDR_W  = 5;
    localparam int PIPE_MAX_LAT = 4;

    typedef logic [PIPE_ADDR_W-1:0] reg_addr_t;

    // Producer latency classes
    localparam int LAT_ALU  = 0;             // resolved by forwarding, never tracked
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = PIPE_MAX_LAT;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter
// Description : One scoreboard entry: a down-counter holding the number of
//               cycles until the tracked register's result can be consumed.
//               A load in the same cycle as a decrement wins.
// Ports       : clk_i   - clock
//               rst_i   - synchronous active-high reset
//               load_i  - load lat_i into the counter
//               lat_i   - latency to load
//               cnt_o   - current count
//               nz_o    - count is nonzero (register still pending)
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter
    import pipe_pkg::*;
#(
    parameter int LAT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic [LAT_W-1:0] cnt_o,
    output logic             nz_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = lat_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign nz_o  = (cnt_q != '0);

endmodule : sb_counter
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : ID-stage scoreboard. Tracks every in-flight destination
//               register with a down-counter, stalls the issuing instruction
//               on RAW or WAW conflicts and counts stalled cycles
//               (saturating).
// Ports       : clk_i, rst_i           - clock, synchronous active-high reset
//               issue_*_i              - instruction currently in ID
//               cnt_clr_i              - clear the stall counter
//               stall_o                - hold PC/IFID, bubble into IDEX
//               pending_o              - per-register in-flight flags
//               stall_cycles_o         - saturating stall cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_LAT  = 4,
    parameter int LAT_W    = $clog2(MAX_LAT + 1),
    parameter int CNT_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    input  logic [ADDR_W-1:0]   issue_rs1_i,
    input  logic [ADDR_W-1:0]   issue_rs2_i,
    input  logic                issue_rs1_used_i,
    input  logic                issue_rs2_used_i,
    input  logic [ADDR_W-1:0]   issue_rd_i,
    input  logic                issue_rd_we_i,
    input  logic [LAT_W-1:0]    issue_lat_i,
    input  logic                cnt_clr_i,
    output logic                stall_o,
    output logic [NUM_REGS-1:0] pending_o,
    output logic [CNT_W-1:0]    stall_cycles_o
);

    localparam logic [LAT_W-1:0] C_MAX_LAT = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] C_LAT_ALU = LAT_W'(LAT_ALU);

    logic [LAT_W-1:0]    w_cnt [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] w_rd_onehot;
    logic [LAT_W-1:0]    w_cnt_rs1;
    logic [LAT_W-1:0]    w_cnt_rs2;
    logic [LAT_W-1:0]    w_cnt_rd;
    logic                w_rd_tracked;
    logic [LAT_W-1:0]    w_lat_eff;
    logic                w_raw;
    logic                w_waw;
    logic                w_accept;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    stall_cnt_d;

    // Oversized latency classes are clamped, not rejected.
    assign w_lat_eff = (issue_lat_i > C_MAX_LAT) ? C_MAX_LAT : issue_lat_i;

    // Counter lookup. x0 and addresses beyond NUM_REGS never match, so they
    // read as "not pending" and can never be loaded.
    always_comb begin
        w_cnt_rs1    = '0;
        w_cnt_rs2    = '0;
        w_cnt_rd     = '0;
        w_rd_tracked = 1'b0;
        w_rd_onehot  = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (issue_rs1_i == ADDR_W'(r)) w_cnt_rs1 = w_cnt[r];
            if (issue_rs2_i == ADDR_W'(r)) w_cnt_rs2 = w_cnt[r];
            if (issue_rd_i == ADDR_W'(r)) begin
                w_cnt_rd       = w_cnt[r];
                w_rd_tracked   = 1'b1;
                w_rd_onehot[r] = 1'b1;
            end
        end
    end

    assign w_raw = (issue_rs1_used_i && (w_cnt_rs1 != '0)) ||
                   (issue_rs2_used_i && (w_cnt_rs2 != '0));

    // A new producer may only overtake an older one to the same rd if it
    // cannot finish first; otherwise the older write would land last.
    assign w_waw = issue_rd_we_i && (w_cnt_rd > w_lat_eff);

    assign stall_o  = issue_valid_i && !rst_i && (w_raw || w_waw);

    assign w_accept = issue_valid_i && !stall_o && issue_rd_we_i &&
                      w_rd_tracked && (w_lat_eff != C_LAT_ALU);

    assign pending_o[0] = 1'b0;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
            sb_counter #(
                .LAT_W (LAT_W)
            ) u_cnt (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .load_i (w_accept && w_rd_onehot[r]),
                .lat_i  (w_lat_eff),
                .cnt_o  (w_cnt[r]),
                .nz_o   (pending_o[r])
            );
        end
    endgenerate

    // Stall performance counter: clear beats increment, holds at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d = '0;
        end else if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;

endmodule : hazard_scoreboard
`default_nettype wire
